// File: rtl/axis_dispatch_pkg.sv
// rtl/axis_dispatch_pkg.sv - shared types, arbitration modes and width helpers for the idle-flag dispatcher
package axis_dispatch_pkg;

  typedef enum logic {
    S_SEL  = 1'b0,
    S_PASS = 1'b1
  } state_t;

  localparam int ARB_LOW  = 0;
  localparam int ARB_RR   = 1;
  localparam int ARB_HIGH = 2;

  function automatic int chn_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  // A zero holdoff still needs a 1-bit counter so the array stays legal.
  function automatic int cnt_width(input int holdoff);
    return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_idle_dispatch_if.sv
// rtl/axis_idle_dispatch_if.sv - N-lane stream bundle; N=1 for the slave side, N=NUM for the master fan-out
interface axis_idle_dispatch_if #(
  parameter int N  = 1,
  parameter int DW = 32
);

  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_dispatch_arb.sv
// rtl/axis_dispatch_arb.sv - combinational channel picker: lowest, round-robin or highest eligible index
module axis_dispatch_arb
  import axis_dispatch_pkg::*;
#(
  parameter int NUM      = 8,
  parameter int ARB_MODE = ARB_LOW,
  localparam int CW      = chn_width(NUM)
) (
  input  logic [NUM-1:0] elig,
  input  logic [CW-1:0]  rr_ptr,
  output logic [CW-1:0]  grant_idx,
  output logic           grant_vld
);

  localparam logic [CW:0] NUM_W = (CW + 1)'(NUM);

  logic [2*NUM-1:0] w_dbl;
  logic [NUM-1:0]   w_rot;
  logic [CW-1:0]    w_low;
  logic [CW-1:0]    w_high;
  logic [CW-1:0]    w_off;
  logic [CW:0]      w_sum;

  // Rotating the request vector by rr_ptr turns "first at or after rr_ptr" into "lowest set bit".
  assign w_dbl = {elig, elig} >> rr_ptr;
  assign w_rot = w_dbl[NUM-1:0];

  always_comb begin
    w_low  = '0;
    w_high = '0;
    w_off  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (elig[i]) w_low = CW'(i);
      if (w_rot[i]) w_off = CW'(i);
    end
    for (int i = 0; i < NUM; i++) begin
      if (elig[i]) w_high = CW'(i);
    end
  end

  always_comb begin
    w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
    if (w_sum >= NUM_W) w_sum = w_sum - NUM_W;
  end

  always_comb begin
    grant_vld = |elig;
    case (ARB_MODE)
      ARB_RR:   grant_idx = w_sum[CW-1:0];
      ARB_HIGH: grant_idx = w_high;
      default:  grant_idx = w_low;
    endcase
  end

endmodule

// File: rtl/axis_idle_dispatch.sv
// rtl/axis_idle_dispatch.sv - packet-level stream demux steering each packet to an idle, non-held-off channel
module axis_idle_dispatch
  import axis_dispatch_pkg::*;
#(
  parameter int NUM      = 8,
  parameter int DSIZE    = 32,
  parameter int ARB_MODE = ARB_LOW,
  parameter int HOLDOFF  = 4,
  localparam int CW      = chn_width(NUM)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       idle_flag,
  axis_idle_dispatch_if.slave  s_axis,
  axis_idle_dispatch_if.master m_axis,
  output logic [CW-1:0]        cur_chn,
  output logic                 busy
);

  localparam int             HW        = cnt_width(HOLDOFF);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [CW-1:0]  LAST_CHN  = CW'(NUM - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cur;
  logic [CW-1:0]    r_rr_ptr;
  logic             r_busy;
  logic             r_rv;
  logic             r_last;
  logic [DSIZE-1:0] r_data;
  logic [HW-1:0]    r_hold [NUM];

  logic [NUM-1:0]   w_elig;
  logic [CW-1:0]    w_grant;
  logic             w_grant_vld;
  logic             w_cur_ready;
  logic             w_s_ready;
  logic             w_s_fire;
  logic             w_m_fire;
  logic             w_pkt_done;

  for (genvar i = 0; i < NUM; i++) begin : g_elig
    assign w_elig[i] = idle_flag[i] & (r_hold[i] == '0);
  end

  axis_dispatch_arb #(
    .NUM      (NUM),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .elig      (w_elig),
    .rr_ptr    (r_rr_ptr),
    .grant_idx (w_grant),
    .grant_vld (w_grant_vld)
  );

  // A buffered tlast blocks the slave so the next packet always re-arbitrates.
  assign w_cur_ready = m_axis.tready[r_cur];
  assign w_s_ready   = (r_state == S_PASS) & ~(r_rv & r_last) & (~r_rv | w_cur_ready);
  assign w_s_fire    = s_axis.tvalid[0] & w_s_ready;
  assign w_m_fire    = r_rv & w_cur_ready;
  assign w_pkt_done  = (r_state == S_PASS) & w_m_fire & r_last;

  assign s_axis.tready = w_s_ready;
  assign m_axis.tdata  = {NUM{r_data}};
  assign cur_chn       = r_cur;
  assign busy          = r_busy;

  for (genvar i = 0; i < NUM; i++) begin : g_mout
    assign m_axis.tvalid[i] = r_rv & (r_cur == CW'(i));
    assign m_axis.tlast[i]  = r_rv & r_last & (r_cur == CW'(i));
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state  <= S_SEL;
      r_cur    <= '0;
      r_rr_ptr <= '0;
      r_busy   <= 1'b0;
      r_rv     <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_SEL: begin
          if (s_axis.tvalid[0] && w_grant_vld) begin
            r_cur   <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_s_fire) begin
            r_rv   <= 1'b1;
            r_data <= s_axis.tdata;
            r_last <= s_axis.tlast[0];
          end else if (w_m_fire) begin
            r_rv <= 1'b0;
          end
          if (w_pkt_done) begin
            r_busy   <= 1'b0;
            r_rr_ptr <= (r_cur == LAST_CHN) ? '0 : r_cur + 1'b1;
            r_state  <= S_SEL;
          end
        end
        default: r_state <= S_SEL;
      endcase
    end
  end

  // Loaded as the tlast leaves, so a channel is only eligible once its counter already reads 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (w_pkt_done && (r_cur == CW'(i))) r_hold[i] <= HOLD_LOAD;
        else if (r_hold[i] != '0)            r_hold[i] <= r_hold[i] - 1'b1;
      end
    end
  end

endmodule
